// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared types and helpers for the debounce_sync conditioning stage.
//   - state_t       : debounce FSM state encoding
//   - min_cnt_width : smallest counter width able to count DEBOUNCE_CYCLES values
package debounce_pkg;

  // STABLE_HI is the only state with both bits set, so bit 1 xor bit 0
  // identifies the two qualification states.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    CHK_HI    = 2'b01,
    STABLE_HI = 2'b11,
    CHK_LO    = 2'b10
  } state_t;

  // Smallest width w (at least 1) with 2**w >= cycles, so the counter
  // can reach cycles-1 without wrapping.
  function automatic int min_cnt_width(input int cycles);
    int w;
    w = 1;
    while ((longint'(1) << w) < longint'(cycles)) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain
//   Multi-flop synchroniser for a single asynchronous bit. Reusable by any
//   CDC input that needs a plain level synchroniser.
//   Parameters:
//     STAGES  number of flops in the chain (>= 2)
//   Ports:
//     clk    in  system clock, rising edge
//     reset  in  asynchronous, active-high reset, clears the whole chain
//     d      in  raw asynchronous input
//     q      out synchronised copy of d, STAGES edges of latency
module sync_chain
  import debounce_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // Shift the raw input in at bit 0; the oldest sample leaves at the top.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// debounce_sync
//   Front-end conditioning for asynchronous inputs (buttons, switches,
//   external strobes). Synchronises din_async, then accepts a change only
//   after it has been seen steadily for DEBOUNCE_CYCLES consecutive cycles
//   in a qualification state. All outputs are registered.
//   Parameters:
//     SYNC_STAGES      synchroniser depth (>= 2)
//     DEBOUNCE_CYCLES  stable cycles required to accept a change (>= 1)
//     CNT_WIDTH        qualification counter width, 2**CNT_WIDTH >= DEBOUNCE_CYCLES
//   Ports:
//     clk         in  system clock, rising edge
//     reset       in  asynchronous, active-high reset
//     din_async   in  raw, unsynchronised input
//     clean       out debounced level
//     rise_pulse  out one-cycle pulse coincident with clean 0->1
//     fall_pulse  out one-cycle pulse coincident with clean 1->0
//     busy        out high while a candidate transition is being qualified
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din_async,
  output logic clean,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  // Reject illegal configurations at elaboration time.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("debounce_sync: DEBOUNCE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("debounce_sync: SYNC_STAGES must be >= 2");
  end
  if (CNT_WIDTH < min_cnt_width(DEBOUNCE_CYCLES)) begin : g_bad_width
    $error("debounce_sync: CNT_WIDTH too small for DEBOUNCE_CYCLES");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic s;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
  logic                 clean_q, clean_d;
  logic                 rise_q,  rise_d;
  logic                 fall_q,  fall_d;
  logic                 busy_q,  busy_d;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (din_async),
    .q     (s)
  );

  // Next-state logic. Any sample disagreeing with the candidate level sends
  // the FSM back to the stable state with cnt cleared, so qualification
  // always restarts from zero. cnt stops at CNT_LAST because reaching it
  // leaves the CHK state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = CHK_HI;
          cnt_d   = '0;
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          clean_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = CHK_LO;
          cnt_d   = '0;
        end
      end
      CHK_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          clean_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase

    // busy is derived from the next state so it is registered alongside it.
    busy_d = (state_d == CHK_HI) || (state_d == CHK_LO);
  end

  // FSM state, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign clean      = clean_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync
//   Directed and random self-checking bench for debounce_sync with
//   SYNC_STAGES=2, DEBOUNCE_CYCLES=4. Outputs are compared as the vector
//   {clean, rise_pulse, fall_pulse, busy}.
module tb_debounce_sync;

  localparam int SS = 2;
  localparam int DC = 4;

  logic clk;
  logic reset;
  logic din_async;
  logic clean;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;
  logic [3:0] obs_vec;

  int tests_run;
  int tests_failed;

  logic       pat_q[$];
  logic [3:0] exp_q[$];

  debounce_sync #(
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC),
    .CNT_WIDTH       (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din_async  (din_async),
    .clean      (clean),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
  );

  assign obs_vec = {clean, rise_pulse, fall_pulse, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and report on mismatch.
  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive pat_q[k] so that it is sampled by edge k+1, then check exp_q[k]
  // on the following falling edge.
  task automatic applyStimulus(input string tag);
    for (int k = 0; k < pat_q.size(); k++) begin
      din_async = pat_q[k];
      @(negedge clk);
      checkOutput($sformatf("%s_e%0d", tag, k + 1), obs_vec, exp_q[k]);
    end
  endtask

  // Random-phase reference: clean flips once the synchronised input has
  // disagreed with it on DC+1 consecutive edges; busy while a run is open.
  logic m_s0, m_s1, s_prev, m_clean, m_rise, m_fall, din_v, prev_clean;
  int   m_run, hold_left, last_pulse, pulse_cnt, toggle_cnt;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    din_async    = 1'b0;

    // Reset state
    #3;
    checkOutput("reset_async", obs_vec, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    pat_q = '{0, 0, 0, 0};
    exp_q = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    applyStimulus("idle");

    // Clean step 0->1
    pat_q = '{1, 1, 1, 1, 1, 1, 1, 1};
    exp_q = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1100, 4'b1000};
    applyStimulus("step_rise");

    // Release 1->0
    pat_q = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_q = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0010, 4'b0000};
    applyStimulus("release");

    // Bounce: 3 high, 1 low, then held high
    pat_q = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    exp_q = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
              4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1100, 4'b1000};
    applyStimulus("bounce");

    pat_q = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_q = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0010, 4'b0000};
    applyStimulus("release2");

    // Glitch rejection: 1-cycle then 3-cycle high pulses
    pat_q = '{1, 0, 0, 0, 0, 0};
    exp_q = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    applyStimulus("glitch1");

    pat_q = '{1, 1, 1, 0, 0, 0, 0, 0};
    exp_q = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    applyStimulus("glitch3");

    // Reset mid CHK_HI with cnt==2, din held high throughout
    pat_q = '{1, 1, 1, 1, 1};
    exp_q = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001};
    applyStimulus("pre_reset");
    #2;
    reset = 1'b1;
    #1;
    checkOutput("reset_mid_async", obs_vec, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_mid_hold", obs_vec, 4'b0000);
    reset = 1'b0;
    pat_q = '{1, 1, 1, 1, 1, 1, 1, 1};
    exp_q = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1100, 4'b1000};
    applyStimulus("post_reset");

    pat_q = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_q = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0010, 4'b0000};
    applyStimulus("release3");

    // Random bouncy stimulus against the reference model
    m_s0       = 1'b0;
    m_s1       = 1'b0;
    m_clean    = 1'b0;
    m_run      = 0;
    din_v      = 1'b0;
    hold_left  = 0;
    last_pulse = 2;
    pulse_cnt  = 0;
    toggle_cnt = 0;
    prev_clean = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (hold_left == 0) begin
        din_v     = ~din_v;
        hold_left = $urandom_range(1, 9);
      end
      hold_left--;
      din_async = din_v;
      @(negedge clk);

      s_prev = m_s1;
      m_s1   = m_s0;
      m_s0   = din_v;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s_prev != m_clean) begin
        m_run++;
        if (m_run == DC + 1) begin
          m_clean = s_prev;
          m_rise  = s_prev;
          m_fall  = ~s_prev;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      checkOutput($sformatf("rand_c%0d", cyc), obs_vec,
                  {m_clean, m_rise, m_fall, (m_run != 0)});

      if (rise_pulse === 1'b1) begin
        checkOutput($sformatf("rand_alt_rise_c%0d", cyc), 4'(last_pulse), 4'd2);
        last_pulse = 1;
        pulse_cnt++;
      end
      if (fall_pulse === 1'b1) begin
        checkOutput($sformatf("rand_alt_fall_c%0d", cyc), 4'(last_pulse), 4'd1);
        last_pulse = 2;
        pulse_cnt++;
      end
      if (clean !== prev_clean) begin
        toggle_cnt++;
      end
      prev_clean = clean;
    end
    tests_run++;
    assert (pulse_cnt == toggle_cnt)
    else begin
      tests_failed++;
      $error("[TB] FAIL rand_pulse_count: observed %0d expected %0d", pulse_cnt, toggle_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
